// File: rtl/fifo_sc_ew_req_sp_sram_pack_pkg.sv
// Shared helpers for the packed single-port-SRAM FIFO.
package fifo_sc_ew_req_sp_sram_pack_pkg;

  // Ceiling log2. The result is never below 1 so that every derived bus has at least one bit.
  function automatic int func_log2(input int val);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < val) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sc_ew_req_sp_sram_pack_sram_sp_model.sv
// Single-port SRAM behavioural model: one access per cycle, registered read data.
module sram_sp_model
  import fifo_sc_ew_req_sp_sram_pack_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int DATA_WD = 16,
  localparam int AW     = func_log2(DEPTH)
) (
  input  logic               clk,
  input  logic               i_cs,
  input  logic               i_we,
  input  logic [AW-1:0]      i_addr,
  input  logic [DATA_WD-1:0] i_din,
  output logic [DATA_WD-1:0] o_dout
);

  logic [DATA_WD-1:0] r_mem [DEPTH];
  logic [DATA_WD-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (i_cs) begin
      if (i_we) r_mem[i_addr] <= i_din;
      else      r_dout        <= r_mem[i_addr];
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/fifo_sc_ew_req_sp_sram_pack.sv
// Exact-width FIFO on a packed single-port SRAM, with a write-pack buffer, a read-unpack
// buffer and a bypass path so that reads always return one cycle after the request.
module fifo_sc_ew_req_sp_sram_pack
  import fifo_sc_ew_req_sp_sram_pack_pkg::*;
#(
  parameter int SIZE         = 64,
  parameter int DATA_WD      = 8,
  parameter int RATIO        = 2,
  parameter int KNOB_LOG     = 0,
  parameter     NAME_LOG_INP = "",
  parameter     NAME_LOG_OUT = "",
  localparam int SIZE_WD     = func_log2(SIZE)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               wr_val_i,
  input  logic [DATA_WD-1:0] wr_dat_i,
  output logic               wr_ful_o,
  input  logic               rd_val_i,
  output logic               rd_val_o,
  output logic [DATA_WD-1:0] rd_dat_o,
  output logic               rd_ept_o,
  output logic [SIZE_WD:0]   wd_usd_o
);

  localparam int SRAM_DEPTH = SIZE / RATIO - 4;
  localparam int SRAM_WD    = DATA_WD * RATIO;
  localparam int SA_WD      = func_log2(SRAM_DEPTH);
  localparam int SC_WD      = func_log2(SRAM_DEPTH + 1);
  localparam int US_WD      = SIZE_WD + 1;
  localparam int RB_N       = 2 * RATIO;
  localparam int RB_PW      = func_log2(RB_N);
  localparam int RB_CW      = RB_PW + 1;
  // With the SRAM full and more than RATIO entries parked in rbuf, up to 3*RATIO-1
  // entries can queue on the write side, so wbuf gets 4*RATIO slots of headroom.
  localparam int WB_N       = 4 * RATIO;
  localparam int WB_PW      = func_log2(WB_N);
  localparam int WB_CW      = WB_PW + 1;
  localparam logic [SA_WD-1:0] SA_LAST = SA_WD'(SRAM_DEPTH - 1);

  logic [DATA_WD-1:0] r_rbuf [RB_N];
  logic [DATA_WD-1:0] r_wbuf [WB_N];
  logic [RB_PW-1:0]   r_rb_rp, r_rb_wp;
  logic [RB_CW-1:0]   r_rb_cnt;
  logic [WB_PW-1:0]   r_wb_rp, r_wb_wp;
  logic [WB_CW-1:0]   r_wb_cnt;
  logic [SC_WD-1:0]   r_sram_cnt;
  logic [SA_WD-1:0]   r_sram_wa, r_sram_ra;
  logic               r_rd_fly;
  logic               r_rd_val;
  logic [DATA_WD-1:0] r_rd_dat;

  logic               w_pop_rb, w_pop_wb;
  logic [RB_CW-1:0]   w_rb_free;
  logic               w_rb_room;
  logic [WB_CW-1:0]   w_wb_avail;
  logic               w_pend, w_sram_emp;
  logic               w_rd_issue, w_bypass, w_sram_wr, w_commit, w_rb_push;
  logic [SRAM_WD-1:0] w_pack_word, w_rb_word, w_sram_dout;
  logic [DATA_WD-1:0] w_pop_dat;
  logic [SA_WD-1:0]   w_sram_addr;

  assign w_pop_rb   = rd_val_i && (r_rb_cnt != '0);
  assign w_pop_wb   = rd_val_i && (r_rb_cnt == '0);
  assign w_rb_free  = RB_CW'(RB_N) - r_rb_cnt + RB_CW'(w_pop_rb);
  assign w_rb_room  = w_rb_free >= RB_CW'(RATIO);
  assign w_wb_avail = r_wb_cnt - WB_CW'(w_pop_wb);
  assign w_pend     = w_wb_avail >= WB_CW'(RATIO);
  assign w_sram_emp = r_sram_cnt == '0;

  // SRAM read wins the port; a blocked commit simply retries next cycle.
  assign w_rd_issue = !w_sram_emp && !r_rd_fly && w_rb_room;
  assign w_bypass   = w_pend && w_sram_emp && !r_rd_fly && w_rb_room;
  assign w_sram_wr  = w_pend && !w_bypass && !w_rd_issue && (r_sram_cnt != SC_WD'(SRAM_DEPTH));
  assign w_commit   = w_bypass || w_sram_wr;
  assign w_rb_push  = w_bypass || r_rd_fly;
  assign w_rb_word  = r_rd_fly ? w_sram_dout : w_pack_word;
  assign w_sram_addr = w_rd_issue ? r_sram_ra : r_sram_wa;

  // Oldest entry lands in the LSB slice; skip the head if it is being popped this cycle.
  always_comb begin
    w_pack_word = '0;
    for (int i = 0; i < RATIO; i++) begin
      w_pack_word[i*DATA_WD +: DATA_WD] = r_wbuf[r_wb_rp + WB_PW'(w_pop_wb) + WB_PW'(i)];
    end
  end

  assign w_pop_dat = (r_rb_cnt != '0) ? r_rbuf[r_rb_rp] : r_wbuf[r_wb_rp];

  sram_sp_model #(
    .DEPTH   (SRAM_DEPTH),
    .DATA_WD (SRAM_WD)
  ) u_sram (
    .clk    (clk),
    .i_cs   (w_rd_issue || w_sram_wr),
    .i_we   (w_sram_wr),
    .i_addr (w_sram_addr),
    .i_din  (w_pack_word),
    .o_dout (w_sram_dout)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rb_rp    <= '0;
      r_rb_wp    <= '0;
      r_rb_cnt   <= '0;
      r_wb_rp    <= '0;
      r_wb_wp    <= '0;
      r_wb_cnt   <= '0;
      r_sram_cnt <= '0;
      r_sram_wa  <= '0;
      r_sram_ra  <= '0;
      r_rd_fly   <= 1'b0;
      r_rd_val   <= 1'b0;
      r_rd_dat   <= '0;
    end else begin
      r_rd_val <= rd_val_i;
      if (rd_val_i) r_rd_dat <= w_pop_dat;

      r_rb_rp  <= r_rb_rp + RB_PW'(w_pop_rb);
      if (w_rb_push) r_rb_wp <= r_rb_wp + RB_PW'(RATIO);
      r_rb_cnt <= r_rb_cnt + (w_rb_push ? RB_CW'(RATIO) : '0) - RB_CW'(w_pop_rb);

      r_wb_rp  <= r_wb_rp + WB_PW'(w_pop_wb) + (w_commit ? WB_PW'(RATIO) : '0);
      r_wb_wp  <= r_wb_wp + WB_PW'(wr_val_i);
      r_wb_cnt <= r_wb_cnt + WB_CW'(wr_val_i) - WB_CW'(w_pop_wb)
                  - (w_commit ? WB_CW'(RATIO) : '0);

      r_sram_cnt <= r_sram_cnt + SC_WD'(w_sram_wr) - SC_WD'(w_rd_issue);
      if (w_sram_wr)  r_sram_wa <= (r_sram_wa == SA_LAST) ? '0 : r_sram_wa + SA_WD'(1);
      if (w_rd_issue) r_sram_ra <= (r_sram_ra == SA_LAST) ? '0 : r_sram_ra + SA_WD'(1);
      r_rd_fly <= w_rd_issue;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_val_i) r_wbuf[r_wb_wp] <= wr_dat_i;
    if (w_rb_push) begin
      for (int i = 0; i < RATIO; i++) begin
        r_rbuf[r_rb_wp + RB_PW'(i)] <= w_rb_word[i*DATA_WD +: DATA_WD];
      end
    end
  end

  assign wd_usd_o = US_WD'(r_rb_cnt) + US_WD'(r_wb_cnt)
                  + US_WD'(r_sram_cnt) * US_WD'(RATIO)
                  + (r_rd_fly ? US_WD'(RATIO) : '0);
  assign wr_ful_o = wd_usd_o >= US_WD'(SIZE);
  assign rd_ept_o = wd_usd_o == '0;
  assign rd_val_o = r_rd_val;
  assign rd_dat_o = r_rd_dat;

`ifdef SIM_KNOB_DBG
  always_ff @(posedge clk) begin
    if (rstn) begin
      if (wr_val_i && wr_ful_o) $fatal(1, "fifo push while full");
      if (rd_val_i && rd_ept_o) $fatal(1, "fifo pop while empty");
      if (rd_val_i && (wd_usd_o != '0))
        assert ((r_rb_cnt != '0) || (w_sram_emp && !r_rd_fly))
          else $error("fifo read head not ready in rbuf");
    end
  end
`endif

endmodule
